// File: rtl/arb8_scheduler_if.sv
// Bus bundle for arb8_scheduler.
//   en          : arbitration enable; 0 blocks new grants and revokes the current one
//   mode        : 0 = fixed priority (index 7 highest), 1 = round-robin
//   req[7:0]    : level-sensitive request lines
//   rel         : current grantee finished (named rel because release is a reserved word)
//   grant[7:0]  : one-hot grant, zero when nothing granted
//   grant_id    : index of the most recent winner
//   grant_valid : high exactly when grant is nonzero
//   timeout     : one-cycle pulse after a grant ended by hold expiry
interface arb8_scheduler_if;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output en, mode, req, rel,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  en, mode, req, rel,
        output grant, grant_id, grant_valid, timeout
    );
endinterface

// File: rtl/arb8_scheduler.sv
// Eight-way arbiter with fixed-priority or round-robin selection, a per-grant hold limit and a
// one-cycle dead gap between grants.
//   clk      : system clock, rising edge
//   clrn     : asynchronous active-low reset
//   bus      : arb8_scheduler_if.slave (en, mode, req, rel in; grant, grant_id, grant_valid,
//              timeout out)
//   MAX_HOLD : maximum consecutive grant cycles per requester, 1..15
module arb8_scheduler #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              clrn,
    arb8_scheduler_if.slave   bus
);

    localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e     state_q, state_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic [2:0] winner;
    logic       arb;
    logic       normal_exit;
    logic       hold_done;

    // Winner selection. Both loops let the preferred candidate be assigned last.
    always_comb begin
        winner = 3'd0;
        if (bus.mode) begin
            for (int k = 7; k >= 0; k--) begin
                if (bus.req[ptr_q + 3'(k)]) winner = ptr_q + 3'(k);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus.req[i]) winner = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= StIdle;
            grant_id_q <= 3'd0;
            ptr_q      <= 3'd0;
            hold_q     <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        arb         = (state_q != StGrant) && bus.en && (bus.req != 8'h00);
        normal_exit = bus.rel || !bus.req[grant_id_q] || !bus.en;
        hold_done   = (hold_q == HoldLast);
        state_d     = StIdle;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle, StGap: begin
                if (arb) begin
                    state_d    = StGrant;
                    grant_id_d = winner;
                    ptr_d      = winner + 3'd1;
                    hold_d     = 4'd0;
                end
            end
            StGrant: begin
                hold_d = hold_q + 4'd1;
                if (normal_exit || hold_done) begin
                    state_d   = StGap;
                    // Expiry coinciding with a normal exit is not reported as a timeout.
                    timeout_d = hold_done && !normal_exit;
                end else begin
                    state_d = StGrant;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.grant       = 8'h00;
        bus.grant_valid = 1'b0;
        if (state_q == StGrant) begin
            bus.grant       = 8'h01 << grant_id_q;
            bus.grant_valid = 1'b1;
        end
        bus.grant_id = grant_id_q;
        bus.timeout  = timeout_q;
    end

endmodule

// File: tb/tb_arb8_scheduler.sv
// Directed bench for arb8_scheduler (MAX_HOLD = 4): a per-cycle vector table followed by a
// hand-written asynchronous reset sequence.
module tb_arb8_scheduler;

    typedef struct {
        logic       en;
        logic       mode;
        logic [7:0] req;
        logic       rel;
        logic [7:0] grant;
        logic [2:0] gid;
        logic       to;
    } vec_t;

    logic clk;
    logic clrn;
    int   tests;
    int   failed;
    vec_t vecs[$];

    arb8_scheduler_if bus ();

    arb8_scheduler #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic en, input logic mode, input logic [7:0] req, input logic rel,
                       input logic [7:0] grant, input logic [2:0] gid, input logic to);
        vec_t v;
        v.en = en; v.mode = mode; v.req = req; v.rel = rel;
        v.grant = grant; v.gid = gid; v.to = to;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] grant, input logic [2:0] gid,
                         input logic to);
        logic valid;
        valid = (grant != 8'h00);
        tests++;
        if (bus.grant !== grant || bus.grant_id !== gid || bus.grant_valid !== valid ||
            bus.timeout !== to) begin
            failed++;
            $display("FAIL %s: got grant=%h id=%0d valid=%b to=%b, want grant=%h id=%0d valid=%b to=%b",
                     name, bus.grant, bus.grant_id, bus.grant_valid, bus.timeout,
                     grant, gid, valid, to);
        end
        tests++;
        if (bus.grant_valid !== (bus.grant != 8'h00) || $countones(bus.grant) > 1) begin
            failed++;
            $display("FAIL %s invariant: grant=%h valid=%b", name, bus.grant, bus.grant_valid);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Round-robin, req=FF, release held: ids 0..7,0 with a gap after each grant.
        for (int k = 0; k < 9; k++) begin
            add(1, 1, 8'hFF, 1, 8'h01 << (k % 8), 3'(k % 8), 0);
            add(1, 1, 8'hFF, 1, 8'h00, 3'(k % 8), 0);
        end
        // Fixed priority, req=26: id 5 for 3 cycles, release, gap, re-grant.
        add(1, 0, 8'h26, 0, 8'h20, 3'd5, 0);
        add(1, 0, 8'h26, 0, 8'h20, 3'd5, 0);
        add(1, 0, 8'h26, 0, 8'h20, 3'd5, 0);
        add(1, 0, 8'h26, 1, 8'h00, 3'd5, 0);
        add(1, 0, 8'h26, 0, 8'h20, 3'd5, 0);
        add(1, 0, 8'h26, 1, 8'h00, 3'd5, 0);
        add(0, 0, 8'h26, 0, 8'h00, 3'd5, 0);
        // Hold expiry: 4 grant cycles, timeout gap, re-grant; release in 4th cycle -> no timeout.
        for (int k = 0; k < 4; k++) add(1, 0, 8'h08, 0, 8'h08, 3'd3, 0);
        add(1, 0, 8'h08, 0, 8'h00, 3'd3, 1);
        for (int k = 0; k < 4; k++) add(1, 0, 8'h08, 0, 8'h08, 3'd3, 0);
        add(1, 0, 8'h08, 1, 8'h00, 3'd3, 0);
        add(1, 0, 8'h08, 0, 8'h08, 3'd3, 0);
        // Req drop.
        add(1, 0, 8'h00, 0, 8'h00, 3'd3, 0);
        add(1, 0, 8'h04, 0, 8'h04, 3'd2, 0);
        add(1, 0, 8'h04, 0, 8'h04, 3'd2, 0);
        add(1, 0, 8'h00, 0, 8'h00, 3'd2, 0);
        add(1, 0, 8'h00, 0, 8'h00, 3'd2, 0);
        add(1, 0, 8'h04, 0, 8'h04, 3'd2, 0);
        add(1, 0, 8'h11, 0, 8'h00, 3'd2, 0);
        add(1, 0, 8'h11, 0, 8'h10, 3'd4, 0);
        add(1, 0, 8'h91, 0, 8'h10, 3'd4, 0);
        // en=0 during grant, then re-enable.
        add(0, 0, 8'h91, 0, 8'h00, 3'd4, 0);
        add(0, 0, 8'h91, 0, 8'h00, 3'd4, 0);
        add(0, 0, 8'h91, 0, 8'h00, 3'd4, 0);
        add(1, 0, 8'h01, 0, 8'h01, 3'd0, 0);
        // Round-robin from ptr=1 and ptr=0.
        add(1, 0, 8'h01, 1, 8'h00, 3'd0, 0);
        add(1, 1, 8'h81, 0, 8'h80, 3'd7, 0);
        add(1, 1, 8'h81, 1, 8'h00, 3'd7, 0);
        add(1, 1, 8'h81, 0, 8'h01, 3'd0, 0);
        // Req drop coinciding with hold expiry: no timeout.
        for (int k = 0; k < 3; k++) add(1, 1, 8'h81, 0, 8'h01, 3'd0, 0);
        add(1, 1, 8'h80, 0, 8'h00, 3'd0, 0);
        // Round-robin timeout, then pointer skips the expired requester.
        for (int k = 0; k < 4; k++) add(1, 1, 8'h80, 0, 8'h80, 3'd7, 0);
        add(1, 1, 8'h80, 0, 8'h00, 3'd7, 1);
        add(1, 1, 8'h81, 0, 8'h01, 3'd0, 0);

        // Reset state.
        clrn    = 1'b0;
        bus.en  = 1'b0;
        bus.mode = 1'b0;
        bus.req = 8'h00;
        bus.rel = 1'b0;
        #12;
        check("reset", 8'h00, 3'd0, 0);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            bus.en   = vecs[i].en;
            bus.mode = vecs[i].mode;
            bus.req  = vecs[i].req;
            bus.rel  = vecs[i].rel;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].gid, vecs[i].to);
        end

        // Asynchronous reset mid-grant (grant on id 0, ptr=1): outputs drop before the next edge.
        #2;
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        bus.req  = 8'h81;
        bus.rel  = 1'b0;
        clrn     = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 0);
        #1;
        clrn = 1'b1;
        #1;
        check("reset_release", 8'h00, 3'd0, 0);
        @(posedge clk);
        #1;
        check("post_reset_rr", 8'h01, 3'd0, 0);
        @(posedge clk);
        #1;
        check("post_reset_hold", 8'h01, 3'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
